numpad_scanner: RTL and testbench
=================================

Name: numpad_scanner

Overview:
- Upstream keypad front-end for the 4x4 Pmod keypad on the JA header.
- Drives one column low at a time and samples the active-low rows.
- Debounces across full scans and emits a debounced key code, a 16-bit one-hot key vector and press/release pulses.
- Feeds the keypad-to-mole translation stage, which consumes the one-hot vector.

Parameters:
- SCAN_CYCLES, 100000, clocks each column is driven before rows are sampled (1 ms at 100 MHz); must be >= 3.
- DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a change; must be >= 1.
- REPEAT_SCANS, 50, auto-repeat period in scans; used only with the macro.

Ports:
- clk  in  1  100 MHz master clock
- rst_n  in  1  synchronous active-low reset
- rows_n  in  4  keypad rows (JA[7:4]), pulled up, low = pressed in driven column
- cols_n  out  4  keypad column drive (JA[3:0]), one-cold
- key_valid  out  1  debounced key held
- key_row  out  2  debounced row
- key_col  out  2  debounced column
- key_onehot  out  16  bit (row*4+col) set when key_valid, else 0
- key_press  out  1  one-cycle pulse on accepted press or key change
- key_release  out  1  one-cycle pulse on accepted release or key change

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values: cols_n=4'b1110; key_valid=0; key_row=0; key_col=0; key_onehot=0; key_press=0; key_release=0. Settle counter=0, column index=0, candidate cleared, stable_cnt=0, synchronizer=4'b1111.
- rows_n passes through a 2-flop synchronizer before use.
- FSM states: SCAN and EVAL.
- SCAN: drive column c (cols_n bit c low). Count cnt 0..SCAN_CYCLES-1. At cnt==SCAN_CYCLES-1, sample the synchronized rows.
  - If no hit is recorded yet this scan and any row is low, record the lowest-index low row with column c.
  - Then c increments. After column 3, go to EVAL.
- EVAL (1 cycle): candidate = {found,row,col}.
  - If candidate equals the previous candidate, stable_cnt increments (saturating at DEBOUNCE_SCANS).
  - Otherwise stable_cnt=1 and the previous candidate is replaced.
  - The hit record clears. Next cycle returns to SCAN at column 0, cnt 0, cols_n=1110.
- One full scan = 4*SCAN_CYCLES+1 cycles.
- Acceptance: on the EVAL where stable_cnt reaches or equals DEBOUNCE_SCANS and the candidate differs from the debounced state, outputs update on that edge, visible the next cycle:
  - idle->key: key_press=1, key_valid=1, row/col/onehot loaded.
  - key->idle: key_release=1, key_valid=0, onehot=0. key_row/key_col hold their last values.
  - keyA->keyB: key_press and key_release both pulse the same cycle; outputs switch to B.
- Pulses are high exactly one cycle.
- Multiple keys pressed: the first hit in scan order (column-major, column 0 first, lowest row) wins. No ghost rejection.
- Reset mid-scan: all state returns to reset values on the next edge. A held key needs DEBOUNCE_SCANS fresh scans to be re-accepted. No release pulse is emitted for a key cleared by reset.

Optional Feature:
- Macro: NUMPAD_AUTOREPEAT_EN.
- Defined: while key_valid and the same key stays stable, a repeat counter increments every EVAL. On reaching REPEAT_SCANS it pulses key_press and clears, repeating every REPEAT_SCANS scans. The counter clears on any acceptance or release.
- Undefined: exactly one key_press per accepted press; no repeat logic.

Decomposition:
- numpad_pkg:
  - NUM_ROWS=4, NUM_COLS=4
  - state encodings ST_SCAN, ST_EVAL
  - COLS_IDLE=4'b1111
  - key-index function row*4+col
- Sub-module numpad_row_sync: 4-bit 2-flop synchronizer, reset to 4'b1111.

Test Plan:
Bench settings: SCAN_CYCLES=4, DEBOUNCE_SCANS=3, scan=17 cycles. Keypad model pulls row r low when column c is driven and key (r,c) is held. Cycle 0 is the first cycle with rst_n=1.
1. rst_n low 3 cycles -> cols_n=1110, all key outputs 0. After release, cols_n steps 1110->1101->1011->0111 every 4 cycles, then back to 1110 after EVAL at cycle 16.
2. Hold (r1,c2) from cycle 0 -> single key_press at cycle 51; key_row=1, key_col=2, key_onehot=16'h0040, key_valid=1. No further pulses over 10 scans with macro off.
3. Toggle (r3,c0) every scan for 4 scans, then hold -> no key_press during toggling. key_press 3 scans after hold begins, key_onehot=16'h1000.
4. Release a held key -> key_release pulse after 3 idle scans; key_onehot=0, key_valid=0, no key_press.
5. Hold (r0,c3) and (r2,c1) together -> reported key_row=2, key_col=1, key_onehot=16'h0200.
6. Assert rst_n for 1 cycle mid-scan with key_valid=1 and key still held -> outputs 0 next cycle, scan restarts at 1110, key_press re-asserts 3 scans later. With NUMPAD_AUTOREPEAT_EN and REPEAT_SCANS=2, key_press also repeats every 34 cycles.

Source files
------------

// File: rtl/numpad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package numpad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // All columns released; driven while the scan is being evaluated.
  localparam logic [3:0] COLS_IDLE = 4'b1111;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_EVAL = 1'b1
  } state_t;

  // One scan's result: whether a key was seen and where.
  typedef struct packed {
    logic       found;
    logic [1:0] row;
    logic [1:0] col;
  } cand_t;

  // Bit position of a key in the one-hot vector (row*4+col).
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/numpad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Latency: 2 clk cycles from pin to output.
// Backpressure: none; free-running.
module numpad_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows_n_i,
  output logic [3:0] rows_n_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Two register stages; reset to "no row pulled low".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= rows_n_i;
      sync_q <= meta_q;
    end
  end

  assign rows_n_o = sync_q;

endmodule

// File: rtl/numpad_scanner.sv
// 4x4 keypad column scanner with full-scan debounce; emits key code, one-hot vector and press/release pulses.
// Latency: a key change is reported after DEBOUNCE_SCANS identical scans (scan = 4*SCAN_CYCLES+1 clocks).
// Backpressure: none; outputs are level/pulse. NUMPAD_AUTOREPEAT_EN adds periodic key_press while a key is held.
module numpad_scanner
  import numpad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rows_n,
  output logic [3:0]  cols_n,
  output logic        key_valid,
  output logic [1:0]  key_row,
  output logic [1:0]  key_col,
  output logic [15:0] key_onehot,
  output logic        key_press,
  output logic        key_release
);

  localparam int CNT_W = $clog2(SCAN_CYCLES);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

  // Reject configurations the scan timing cannot support.
  if (SCAN_CYCLES < 3 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("numpad_scanner: invalid parameter set");
  end

  logic [3:0]       rows_sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       scan_col_q, scan_col_d;
  cand_t            hit_q, hit_d;
  cand_t            prev_q, prev_d;
  logic [STB_W-1:0] stable_q, stable_d, stable_next;
  logic             valid_q, valid_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      onehot_q, onehot_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [1:0]       low_row;
  logic             any_low;
  logic             same_key;
  logic             differs;

`ifdef NUMPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
`endif

  numpad_row_sync u_row_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rows_n_i (rows_n),
    .rows_n_o (rows_sync)
  );

  // Lowest-index low row among the synchronized rows.
  always_comb begin
    low_row = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!rows_sync[r]) low_row = 2'(r);
    end
    any_low = ~&rows_sync;
  end

  // Scan sequencing, debounce, acceptance and pulse generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scan_col_d = scan_col_q;
    hit_d      = hit_q;
    prev_d     = prev_q;
    stable_d   = stable_q;
    valid_d    = valid_q;
    row_d      = row_q;
    col_d      = col_q;
    onehot_d   = onehot_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
`ifdef NUMPAD_AUTOREPEAT_EN
    rep_d      = rep_q;
    rep_inc    = rep_q + REP_W'(1);
`endif

    // The scan result matches the key currently reported as held.
    same_key = valid_q && hit_q.found && (hit_q.row == row_q) && (hit_q.col == col_q);
    // The scan result is a different debounced state from what is reported.
    differs  = !(same_key || (!hit_q.found && !valid_q));

    if (hit_q == prev_q) begin
      stable_next = (stable_q == STB_W'(DEBOUNCE_SCANS)) ? stable_q : stable_q + STB_W'(1);
    end else begin
      stable_next = STB_W'(1);
    end

    cols_n = (state_q == ST_EVAL) ? COLS_IDLE : ~(4'b0001 << scan_col_q);

    case (state_q)
      ST_SCAN: begin
        if (cnt_q == CNT_W'(SCAN_CYCLES - 1)) begin
          cnt_d = '0;
          // First hit in column-major order wins; later hits are ignored.
          if (!hit_q.found && any_low) begin
            hit_d = '{found: 1'b1, row: low_row, col: scan_col_q};
          end
          if (scan_col_q == 2'(NUM_COLS - 1)) begin
            state_d = ST_EVAL;
          end else begin
            scan_col_d = scan_col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        prev_d     = hit_q;
        stable_d   = stable_next;
        hit_d      = '0;
        state_d    = ST_SCAN;
        scan_col_d = '0;
        cnt_d      = '0;
        if (stable_next >= STB_W'(DEBOUNCE_SCANS) && differs) begin
          if (hit_q.found) begin
            valid_d   = 1'b1;
            row_d     = hit_q.row;
            col_d     = hit_q.col;
            onehot_d  = 16'd1 << key_index(hit_q.row, hit_q.col);
            press_d   = 1'b1;
            release_d = valid_q;
          end else begin
            valid_d   = 1'b0;
            onehot_d  = '0;
            release_d = 1'b1;
          end
`ifdef NUMPAD_AUTOREPEAT_EN
          rep_d = '0;
`endif
        end
`ifdef NUMPAD_AUTOREPEAT_EN
        else if (same_key) begin
          if (rep_inc == REP_W'(REPEAT_SCANS)) begin
            press_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_inc;
          end
        end else begin
          rep_d = '0;
        end
`endif
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_SCAN;
      cnt_q      <= '0;
      scan_col_q <= '0;
      hit_q      <= '0;
      prev_q     <= '0;
      stable_q   <= '0;
      valid_q    <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      onehot_q   <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scan_col_q <= scan_col_d;
      hit_q      <= hit_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      valid_q    <= valid_d;
      row_q      <= row_d;
      col_q      <= col_d;
      onehot_q   <= onehot_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

`ifdef NUMPAD_AUTOREPEAT_EN
  // Auto-repeat scan counter.
  always_ff @(posedge clk) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  assign key_valid   = valid_q;
  assign key_row     = row_q;
  assign key_col     = col_q;
  assign key_onehot  = onehot_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_numpad_scanner.sv
// Directed bench for numpad_scanner: SCAN_CYCLES=4, DEBOUNCE_SCANS=3 (17-cycle scan).
// Cycle 0 is the first cycle with rst_n high; outputs sampled 1 time unit after each rising edge.
// A combinational keypad model pulls row r low while column c is driven and key (r,c) is held.
module tb_numpad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic        key_valid;
  logic [1:0]  key_row;
  logic [1:0]  key_col;
  logic [15:0] key_onehot;
  logic        key_press;
  logic        key_release;
  logic [15:0] keys_held = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

`ifdef NUMPAD_AUTOREPEAT_EN
  localparam int EXP_HOLD_PRESSES = 6;  // 51 then every 34 cycles up to 221
  localparam int EXP_RST_PRESSES  = 2;  // 51 and 85
`else
  localparam int EXP_HOLD_PRESSES = 1;
  localparam int EXP_RST_PRESSES  = 1;
`endif

  numpad_scanner #(
    .SCAN_CYCLES   (4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rows_n     (rows_n),
    .cols_n     (cols_n),
    .key_valid  (key_valid),
    .key_row    (key_row),
    .key_col    (key_col),
    .key_onehot (key_onehot),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_held[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_cols;
    keys_held = '0;
    rst_n = 1'b0;
    step(); step(); step();
    n_cmp++; if (cols_n !== 4'b1110) begin n_err++; $display("FAIL reset_cols got=%b exp=1110", cols_n); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    n_cmp++; if (key_row !== 2'd0 || key_col !== 2'd0) begin n_err++; $display("FAIL reset_rowcol got=%0d/%0d exp=0/0", key_row, key_col); end
    n_cmp++; if (key_onehot !== 16'h0) begin n_err++; $display("FAIL reset_onehot got=%h exp=0000", key_onehot); end
    n_cmp++; if (key_press !== 1'b0 || key_release !== 1'b0) begin n_err++; $display("FAIL reset_pulses got=%b%b exp=00", key_press, key_release); end
    rst_n = 1'b1;
    cyc = 0;
    while (cyc <= 17) begin
      if (cyc == 0 || cyc == 4 || cyc == 8 || cyc == 12 || cyc == 17) begin
        case (cyc)
          4:       exp_cols = 4'b1101;
          8:       exp_cols = 4'b1011;
          12:      exp_cols = 4'b0111;
          default: exp_cols = 4'b1110;
        endcase
        n_cmp++;
        if (cols_n !== exp_cols) begin n_err++; $display("FAIL scan_cols cyc=%0d got=%b exp=%b", cyc, cols_n, exp_cols); end
      end
      step();
    end
  endtask

  task automatic test_single_press();
    int first = -1;
    int pc = 0;
    int rc = 0;
    keys_held = 16'h0040;
    do_reset();
    while (cyc <= 221) begin
      if (key_press) begin pc++; if (first < 0) first = cyc; end
      if (key_release) rc++;
      step();
    end
    n_cmp++; if (first != 51) begin n_err++; $display("FAIL press_cycle got=%0d exp=51", first); end
    n_cmp++; if (pc != EXP_HOLD_PRESSES) begin n_err++; $display("FAIL press_count got=%0d exp=%0d", pc, EXP_HOLD_PRESSES); end
    n_cmp++; if (rc != 0) begin n_err++; $display("FAIL hold_release_count got=%0d exp=0", rc); end
    n_cmp++; if (key_valid !== 1'b1 || key_row !== 2'd1 || key_col !== 2'd2) begin
      n_err++; $display("FAIL hold_key got v=%b r=%0d c=%0d exp v=1 r=1 c=2", key_valid, key_row, key_col); end
    n_cmp++; if (key_onehot !== 16'h0040) begin n_err++; $display("FAIL hold_onehot got=%h exp=0040", key_onehot); end
  endtask

  task automatic test_debounce_toggle();
    int first = -1;
    int pc = 0;
    keys_held = 16'h1000;
    do_reset();
    while (cyc <= 130) begin
      if (cyc / 17 < 4) keys_held = ((cyc / 17) % 2 == 0) ? 16'h1000 : 16'h0000;
      else              keys_held = 16'h1000;
      if (key_press) begin pc++; if (first < 0) first = cyc; end
      step();
    end
    n_cmp++; if (first != 119) begin n_err++; $display("FAIL toggle_press_cycle got=%0d exp=119", first); end
    n_cmp++; if (pc != 1) begin n_err++; $display("FAIL toggle_press_count got=%0d exp=1", pc); end
    n_cmp++; if (key_onehot !== 16'h1000 || key_row !== 2'd3 || key_col !== 2'd0) begin
      n_err++; $display("FAIL toggle_key got onehot=%h r=%0d c=%0d exp onehot=1000 r=3 c=0", key_onehot, key_row, key_col); end
  endtask

  task automatic test_release();
    int first = -1;
    int pc = 0;
    int rc = 0;
    while (cyc < 136) step();
    keys_held = '0;
    while (cyc <= 200) begin
      if (key_release) begin rc++; if (first < 0) first = cyc; end
      if (key_press) pc++;
      step();
    end
    n_cmp++; if (first != 187) begin n_err++; $display("FAIL release_cycle got=%0d exp=187", first); end
    n_cmp++; if (rc != 1) begin n_err++; $display("FAIL release_count got=%0d exp=1", rc); end
    n_cmp++; if (pc != 0) begin n_err++; $display("FAIL release_press_count got=%0d exp=0", pc); end
    n_cmp++; if (key_valid !== 1'b0 || key_onehot !== 16'h0) begin
      n_err++; $display("FAIL release_state got v=%b onehot=%h exp v=0 onehot=0000", key_valid, key_onehot); end
    n_cmp++; if (key_row !== 2'd3 || key_col !== 2'd0) begin
      n_err++; $display("FAIL release_hold_rowcol got=%0d/%0d exp=3/0", key_row, key_col); end
  endtask

  task automatic test_multi_key();
    int first = -1;
    keys_held = 16'h0208;  // (r0,c3) and (r2,c1)
    do_reset();
    while (cyc < 62) begin
      if (key_press && first < 0) first = cyc;
      step();
    end
    n_cmp++; if (first != 51) begin n_err++; $display("FAIL multi_press_cycle got=%0d exp=51", first); end
    n_cmp++; if (key_valid !== 1'b1 || key_row !== 2'd2 || key_col !== 2'd1 || key_onehot !== 16'h0200) begin
      n_err++; $display("FAIL multi_key got v=%b r=%0d c=%0d onehot=%h exp v=1 r=2 c=1 onehot=0200",
                        key_valid, key_row, key_col, key_onehot); end
  endtask

  task automatic test_reset_mid_scan();
    int first = -1;
    int pc = 0;
    int rc = 0;
    rst_n = 1'b0;
    step();
    n_cmp++; if (key_valid !== 1'b0 || key_onehot !== 16'h0 || key_row !== 2'd0 || key_col !== 2'd0) begin
      n_err++; $display("FAIL midrst_state got v=%b r=%0d c=%0d onehot=%h exp all 0", key_valid, key_row, key_col, key_onehot); end
    n_cmp++; if (key_press !== 1'b0 || key_release !== 1'b0) begin
      n_err++; $display("FAIL midrst_pulses got=%b%b exp=00", key_press, key_release); end
    n_cmp++; if (cols_n !== 4'b1110) begin n_err++; $display("FAIL midrst_cols got=%b exp=1110", cols_n); end
    rst_n = 1'b1;
    cyc = 0;
    while (cyc <= 100) begin
      if (key_press) begin pc++; if (first < 0) first = cyc; end
      if (key_release) rc++;
      step();
    end
    n_cmp++; if (first != 51) begin n_err++; $display("FAIL midrst_press_cycle got=%0d exp=51", first); end
    n_cmp++; if (pc != EXP_RST_PRESSES) begin n_err++; $display("FAIL midrst_press_count got=%0d exp=%0d", pc, EXP_RST_PRESSES); end
    n_cmp++; if (rc != 0) begin n_err++; $display("FAIL midrst_release_count got=%0d exp=0", rc); end
    n_cmp++; if (key_onehot !== 16'h0200) begin n_err++; $display("FAIL midrst_onehot got=%h exp=0200", key_onehot); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_debounce_toggle();
    test_release();
    test_multi_key();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
